// File: rtl/rol_shifter16_seq.sv
// rol_shifter16_seq: multi-cycle rotate unit, one bit per clock, start/busy/done handshake.
// Latency: k+1 clocks from the start edge to the done pulse (1 clock for k=0, 16 for k=15).
// Backpressure: none; start is ignored while busy. Define ROL_DIR_EN to add the dir port (right rotate).
module rol_shifter16_seq #(
    parameter int WIDTH = 16,
    parameter int SW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    s,
`ifdef ROL_DIR_EN
    input  logic             dir,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_rot;
    logic [SW-1:0]    cnt;
    logic             last_shift;

    // Final shift of an operation: the counter is about to reach zero.
    assign last_shift = (state == ST_SHIFT) && (cnt == SW'(1));

`ifdef ROL_DIR_EN
    logic dir_q;

    // One-bit rotate of the working register in the captured direction.
    always_comb begin
        sreg_rot = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
        if (dir_q) begin
            sreg_rot = {sreg[0], sreg[WIDTH-1:1]};
        end
    end

    // Direction is captured with the operand and held for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            dir_q <= dir;
        end
    end
`else
    // One-bit left rotate of the working register.
    always_comb begin
        sreg_rot = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero amount skips SHIFT and goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (s == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == SW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs come from the state register only, never from start.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Datapath: capture on accept, rotate in SHIFT, and load dout on entry to DONE
    // so the result is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                sreg <= din;
                cnt  <= s;
                if (s == '0) begin
                    dout <= din;
                end
            end else if (state == ST_SHIFT) begin
                sreg <= sreg_rot;
                cnt  <= cnt - 1'b1;
                if (last_shift) begin
                    dout <= sreg_rot;
                end
            end
        end
    end

endmodule

// File: tb/tb_rol_shifter16_seq.sv
// Testbench for rol_shifter16_seq: directed and random operations against a scoreboard.
// The driver predicts each result and its done cycle; a monitor on the falling edge checks
// busy, done and dout every cycle against that prediction.
module tb_rol_shifter16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic [3:0]  s;
    logic        busy;
    logic        done;
    logic [15:0] dout;
`ifdef ROL_DIR_EN
    logic        dir;
`endif

    rol_shifter16_seq #(.WIDTH(16), .SW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .s     (s),
`ifdef ROL_DIR_EN
        .dir   (dir),
`endif
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    typedef struct {
        logic [15:0] val;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          b_lo;
    int          b_hi;
    logic [15:0] held;
    int          n_cmp;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter; the monitor sees edge n as cyc == n on the following falling edge.
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int k);
        logic [31:0] w;
        w = {16'h0000, x};
        w = (w << k) | (w >> (16 - k));
        return w[15:0];
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] x, input int k);
        return rotl(x, (16 - k) % 16);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Issue one operation once the model says the unit is idle; called on a falling edge.
    task automatic issue(input logic [15:0] d, input int k, input logic rdir, input logic [15:0] exp);
        int e0;
        while (cyc < b_hi + 1) @(negedge clk);
        e0    = cyc + 1;
        start = 1'b1;
        din   = d;
        s     = 4'(k);
`ifdef ROL_DIR_EN
        dir   = rdir;
`endif
        b_lo  = e0;
        b_hi  = e0 + k;
        sb.push_back('{val: exp, at: e0 + k});
        @(negedge clk);
        start = 1'b0;
        din   = 16'h0000;
        s     = 4'd0;
    endtask

    // A start pulse the unit must ignore because it is busy.
    task automatic poke(input logic [15:0] d, input int k);
        start = 1'b1;
        din   = d;
        s     = 4'(k);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= b_hi + 1 && guard < 100) begin
            @(negedge clk);
            guard = guard + 1;
        end
    endtask

    // Monitor: per-cycle check of busy/done/dout against the predicted window and result.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = (cyc >= b_lo) && (cyc <= b_hi);
            exp_done = (sb.size() > 0) && (sb[0].at == cyc);
            check("busy", {15'd0, busy}, {15'd0, exp_busy});
            check("done", {15'd0, done}, {15'd0, exp_done});
            if (exp_done) begin
                held = sb[0].val;
                void'(sb.pop_front());
            end
            check("dout", dout, held);
        end
    end

    initial begin
        logic [15:0] rd;
        int          rk;
        logic        rdr;
        logic [15:0] rexp;
        int          e0;

        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        b_lo  = 1;
        b_hi  = -10;
        held  = 16'h0000;
        start = 1'b0;
        din   = 16'h0000;
        s     = 4'd0;
`ifdef ROL_DIR_EN
        dir   = 1'b0;
`endif
        rst_n = 1'b0;
        #12;
        check("reset_busy", {15'd0, busy}, 16'h0000);
        check("reset_done", {15'd0, done}, 16'h0000);
        check("reset_dout", dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with known results.
        issue(16'h8001, 1, 1'b0, 16'h0003);
        issue(16'h1234, 4, 1'b0, 16'h2341);
        issue(16'hA5A5, 0, 1'b0, 16'hA5A5);
        issue(16'h0001, 15, 1'b0, 16'h8000);

        // Start pulses while busy (mid-shift and on the done cycle) must be ignored.
        issue(16'h00FF, 8, 1'b0, 16'hFF00);
        e0 = b_lo;
        while (cyc < e0 + 2) @(negedge clk);
        poke(16'hFFFF, 3);
        while (cyc < e0 + 8) @(negedge clk);
        poke(16'hFFFF, 5);
        issue(16'h0F0F, 2, 1'b0, 16'h3C3C);
        check("back_to_back_e10", 16'(b_lo - e0), 16'd10);

        // Asynchronous reset in the middle of a shift discards the operation.
        issue(16'hF00F, 10, 1'b0, 16'h0000);
        e0 = b_lo;
        while (cyc < e0 + 4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {15'd0, busy}, 16'h0000);
        check("arst_done", {15'd0, done}, 16'h0000);
        check("arst_dout", dout, 16'h0000);
        sb.delete();
        b_lo = 1;
        b_hi = -10;
        held = 16'h0000;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0002, 1, 1'b0, 16'h0004);

`ifdef ROL_DIR_EN
        issue(16'h1234, 4, 1'b1, 16'h4123);
        issue(16'h1234, 4, 1'b0, 16'h2341);
`endif

        // Random operations, back to back, checked against the arithmetic rotate model.
        for (int i = 0; i < 40; i++) begin
            rd  = 16'($urandom);
            rk  = int'($urandom_range(0, 15));
            rdr = 1'b0;
`ifdef ROL_DIR_EN
            rdr = 1'($urandom_range(0, 1));
`endif
            rexp = rdr ? rotr(rd, rk) : rotl(rd, rk);
            issue(rd, rk, rdr, rexp);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
